// File: rtl/collision_response_latch.sv
`default_nettype none
// ============================================================================
//  Module      : collision_response_latch
//  Description : Waits for the multicycle collision-response math to settle
//                after a qualifying frame tick, commits the post-collision
//                velocities and headings in one cycle, then ignores new
//                collisions for a number of frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module collision_response_latch #(
    parameter int VEL_WIDTH       = 16,
    parameter int ANG_WIDTH       = 10,
    parameter int SETTLE_CYCLES   = 40,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_frame_tick,
    input  logic                        i_collision,
    input  logic signed [VEL_WIDTH-1:0] i_car1_v_x,
    input  logic signed [VEL_WIDTH-1:0] i_car1_v_y,
    input  logic signed [VEL_WIDTH-1:0] i_car2_v_x,
    input  logic signed [VEL_WIDTH-1:0] i_car2_v_y,
    input  logic signed [VEL_WIDTH-1:0] i_car1_v_m,
    input  logic signed [VEL_WIDTH-1:0] i_car2_v_m,
    input  logic signed [ANG_WIDTH-1:0] i_car1_angle,
    input  logic signed [ANG_WIDTH-1:0] i_car2_angle,
    input  logic                        i_clear_count,
    output logic signed [VEL_WIDTH-1:0] o_car1_v_x,
    output logic signed [VEL_WIDTH-1:0] o_car1_v_y,
    output logic signed [VEL_WIDTH-1:0] o_car2_v_x,
    output logic signed [VEL_WIDTH-1:0] o_car2_v_y,
    output logic signed [VEL_WIDTH-1:0] o_car1_v_m,
    output logic signed [VEL_WIDTH-1:0] o_car2_v_m,
    output logic signed [ANG_WIDTH-1:0] o_car1_angle,
    output logic signed [ANG_WIDTH-1:0] o_car2_angle,
    output logic                        o_apply,
    output logic                        o_busy,
    output logic [7:0]                  o_collision_count
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

    // Counter load values; the settle counter counts down to 0 inclusive,
    // so loading SETTLE_CYCLES-1 gives exactly SETTLE_CYCLES settle cycles.
    localparam logic [7:0] C_SETTLE_LOAD   = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] C_COOLDOWN_LOAD = 8'(COOLDOWN_FRAMES);
    localparam bit         C_NO_COOLDOWN   = (COOLDOWN_FRAMES == 0);

    state_t                      state_q,      state_d;
    logic [7:0]                  settle_cnt_q, settle_cnt_d;
    logic [7:0]                  frame_cnt_q,  frame_cnt_d;
    logic                        apply_q,      apply_d;
    logic                        busy_q,       busy_d;
    logic [7:0]                  count_q,      count_d;
    logic signed [VEL_WIDTH-1:0] car1_v_x_q,   car1_v_x_d;
    logic signed [VEL_WIDTH-1:0] car1_v_y_q,   car1_v_y_d;
    logic signed [VEL_WIDTH-1:0] car2_v_x_q,   car2_v_x_d;
    logic signed [VEL_WIDTH-1:0] car2_v_y_q,   car2_v_y_d;
    logic signed [VEL_WIDTH-1:0] car1_v_m_q,   car1_v_m_d;
    logic signed [VEL_WIDTH-1:0] car2_v_m_q,   car2_v_m_d;
    logic signed [ANG_WIDTH-1:0] car1_angle_q, car1_angle_d;
    logic signed [ANG_WIDTH-1:0] car2_angle_q, car2_angle_d;

    // Next-state, counter, capture and registered-output computation.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        car1_v_x_d   = car1_v_x_q;
        car1_v_y_d   = car1_v_y_q;
        car2_v_x_d   = car2_v_x_q;
        car2_v_y_d   = car2_v_y_q;
        car1_v_m_d   = car1_v_m_q;
        car2_v_m_d   = car2_v_m_q;
        car1_angle_d = car1_angle_q;
        car2_angle_d = car2_angle_q;

        case (state_q)
            ST_IDLE: begin
                // A collision only counts when it coincides with a frame tick.
                if (i_frame_tick && i_collision) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = C_SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == 8'd0) begin
                    // Math has settled: snapshot every result on the edge into COMMIT.
                    state_d      = ST_COMMIT;
                    car1_v_x_d   = i_car1_v_x;
                    car1_v_y_d   = i_car1_v_y;
                    car2_v_x_d   = i_car2_v_x;
                    car2_v_y_d   = i_car2_v_y;
                    car1_v_m_d   = i_car1_v_m;
                    car2_v_m_d   = i_car2_v_m;
                    car1_angle_d = i_car1_angle;
                    car2_angle_d = i_car2_angle;
                end else begin
                    settle_cnt_d = settle_cnt_q - 8'd1;
                end
            end
            ST_COMMIT: begin
                if (C_NO_COOLDOWN) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d     = ST_COOLDOWN;
                    frame_cnt_d = C_COOLDOWN_LOAD;
                end
            end
            ST_COOLDOWN: begin
                // Only frame ticks advance the cooldown; the tick that ends it
                // is consumed here and cannot start a new settle.
                if (i_frame_tick) begin
                    frame_cnt_d = frame_cnt_q - 8'd1;
                    if (frame_cnt_q <= 8'd1) begin
                        state_d     = ST_IDLE;
                        frame_cnt_d = 8'd0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear wins over the commit increment; the count saturates at 255.
        count_d = count_q;
        if (i_clear_count) begin
            count_d = 8'd0;
        end else if ((state_q == ST_COMMIT) && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end

        apply_d = (state_d == ST_COMMIT);
        busy_d  = (state_d != ST_IDLE);
    end

    // State, counters and all outputs register here; reset clears everything.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            frame_cnt_q  <= '0;
            apply_q      <= 1'b0;
            busy_q       <= 1'b0;
            count_q      <= '0;
            car1_v_x_q   <= '0;
            car1_v_y_q   <= '0;
            car2_v_x_q   <= '0;
            car2_v_y_q   <= '0;
            car1_v_m_q   <= '0;
            car2_v_m_q   <= '0;
            car1_angle_q <= '0;
            car2_angle_q <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            apply_q      <= apply_d;
            busy_q       <= busy_d;
            count_q      <= count_d;
            car1_v_x_q   <= car1_v_x_d;
            car1_v_y_q   <= car1_v_y_d;
            car2_v_x_q   <= car2_v_x_d;
            car2_v_y_q   <= car2_v_y_d;
            car1_v_m_q   <= car1_v_m_d;
            car2_v_m_q   <= car2_v_m_d;
            car1_angle_q <= car1_angle_d;
            car2_angle_q <= car2_angle_d;
        end
    end

    assign o_car1_v_x        = car1_v_x_q;
    assign o_car1_v_y        = car1_v_y_q;
    assign o_car2_v_x        = car2_v_x_q;
    assign o_car2_v_y        = car2_v_y_q;
    assign o_car1_v_m        = car1_v_m_q;
    assign o_car2_v_m        = car2_v_m_q;
    assign o_car1_angle      = car1_angle_q;
    assign o_car2_angle      = car2_angle_q;
    assign o_apply           = apply_q;
    assign o_busy            = busy_q;
    assign o_collision_count = count_q;

endmodule
`default_nettype wire
